// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the ysyx_24080006 memory subsystem.
//   mem_req_t   : request payload (address, write data, byte strobes, write enable)
//   mem_rsp_t   : response payload (read data, error flag)
//   arb_state_e : memory arbiter FSM states
//   GNT_IFU / GNT_LSU : grant encodings used by the arbiter
package ysyx_24080006_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RSP   = 3'd2,
        ST_ERR   = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24080006_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with a single outstanding
// transaction, round-robin tie breaking and a response watchdog.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1; the source holds valid and payload stable
// until that edge.
//
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_req      : IFU request channel
//   ifu_rsp_valid/ready, ifu_rsp      : IFU response channel
//   lsu_req_valid/ready, lsu_req      : LSU request channel
//   lsu_rsp_valid/ready, lsu_rsp      : LSU response channel
//   mem_req_valid/ready, mem_req      : slave request channel
//   mem_rsp_valid/ready, mem_rsp      : slave response channel
//   dbg_state, dbg_gnt, dbg_last      : FSM state, current grant, last tie winner
//
// TIMEOUT: RSP cycles without a slave response before an error is returned
// to the master; 0 disables the watchdog.
module ysyx_24080006_mem_arbiter
    import ysyx_24080006_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       ifu_req_valid,
    output logic       ifu_req_ready,
    input  mem_req_t   ifu_req,
    output logic       ifu_rsp_valid,
    input  logic       ifu_rsp_ready,
    output mem_rsp_t   ifu_rsp,

    input  logic       lsu_req_valid,
    output logic       lsu_req_ready,
    input  mem_req_t   lsu_req,
    output logic       lsu_rsp_valid,
    input  logic       lsu_rsp_ready,
    output mem_rsp_t   lsu_rsp,

    output logic       mem_req_valid,
    input  logic       mem_req_ready,
    output mem_req_t   mem_req,
    input  logic       mem_rsp_valid,
    output logic       mem_rsp_ready,
    input  mem_rsp_t   mem_rsp,

    output arb_state_e dbg_state,
    output logic       dbg_gnt,
    output logic       dbg_last
);

    localparam int CNT_W = (TIMEOUT <= 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic             gnt;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic             any_req;
    logic             both_req;
    logic             pick;
    logic             gnt_rsp_ready;
    logic             timeout_hit;

    // Single requester wins outright; on a tie the master that did not win
    // the previous tie is chosen.
    function automatic logic rr_pick(input logic ifu_v, input logic lsu_v,
                                     input logic last_gnt);
        if (ifu_v && lsu_v) begin
            return ~last_gnt;
        end else if (lsu_v) begin
            return GNT_LSU;
        end else begin
            return GNT_IFU;
        end
    endfunction

    assign any_req       = ifu_req_valid || lsu_req_valid;
    assign both_req      = ifu_req_valid && lsu_req_valid;
    assign pick          = rr_pick(ifu_req_valid, lsu_req_valid, last);
    assign gnt_rsp_ready = (gnt == GNT_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    assign timeout_hit   = (TIMEOUT != 0) && (cnt == TIMEOUT_CNT);

    assign dbg_state = state;
    assign dbg_gnt   = gnt;
    assign dbg_last  = last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            gnt   <= GNT_IFU;
            last  <= GNT_IFU;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt <= pick;
                        // Only ties move the round-robin pointer.
                        if (both_req) begin
                            last <= pick;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        cnt <= '0;
                    end
                end
                ST_RSP: begin
                    // Stop counting once the limit is hit so the counter
                    // never wraps while leaving for ERR.
                    if (!mem_rsp_valid && !timeout_hit) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid && gnt_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (gnt_rsp_ready) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The slave's late response is swallowed here.
                if (mem_rsp_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp       = '0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp       = '0;
        mem_req_valid = 1'b0;
        mem_req       = '0;
        mem_rsp_ready = 1'b0;
        case (state)
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (gnt == GNT_LSU) begin
                    mem_req       = lsu_req;
                    lsu_req_ready = mem_req_ready;
                end else begin
                    mem_req       = ifu_req;
                    ifu_req_ready = mem_req_ready;
                end
            end
            ST_RSP: begin
                mem_rsp_ready = gnt_rsp_ready;
                if (gnt == GNT_LSU) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rsp       = mem_rsp;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rsp       = mem_rsp;
                end
            end
            ST_ERR: begin
                if (gnt == GNT_LSU) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp.err   = 1'b1;
                end else begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp.err   = 1'b1;
                end
            end
            ST_DRAIN: begin
                mem_rsp_ready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
